// File: rtl/divisor_pkg.sv
// Shared defaults, types and helpers for the multi-channel tick/clock divider.
package divisor_pkg;

  localparam int unsigned NUM_CH_DEF   = 4;
  localparam int unsigned CNT_W_DEF    = 26;
  localparam int unsigned DIV_INIT_DEF = 4999;
  localparam int unsigned CH_W_DEF     = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

  typedef logic [CNT_W_DEF-1:0] div_t;
  typedef logic [CH_W_DEF-1:0]  ch_idx_t;

  // What a channel does on the coming edge, in priority order SYNC > WRAP/COUNT > HOLD.
  typedef enum logic [1:0] {
    ACC_HOLD,
    ACC_COUNT,
    ACC_WRAP,
    ACC_SYNC
  } accion_t;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/canal_divisor.sv
// One divider channel: counter, active/shadow divisor, tick strobe and 50% clock.
module canal_divisor
  import divisor_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pend,
  output logic             tick,
  output logic             clk_div
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act;
  logic [CNT_W-1:0] shd;
  accion_t          accion;
  logic             reload;

  always_comb begin
    accion = ACC_HOLD;
    if (sync)
      accion = ACC_SYNC;
    else if (en)
      accion = (cnt == act) ? ACC_WRAP : ACC_COUNT;
  end

  // A pending divisor is adopted at any point where cnt is (or becomes) zero.
  assign reload = pend && (accion != ACC_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      act     <= DIV_RST;
      shd     <= DIV_RST;
      pend    <= 1'b0;
      tick    <= 1'b0;
      clk_div <= 1'b0;
    end else begin
      tick <= (accion == ACC_WRAP);
      case (accion)
        ACC_SYNC: begin
          cnt     <= '0;
          clk_div <= 1'b0;
        end
        ACC_WRAP: begin
          cnt     <= '0;
          clk_div <= ~clk_div;
        end
        ACC_COUNT: cnt <= cnt + CNT_W'(1);
        default:   if (pend) cnt <= '0;
      endcase
      if (reload)
        act <= shd;
      // A write in the same cycle as a reload stays pending for the next one.
      if (wr) begin
        shd  <= wr_div;
        pend <= 1'b1;
      end else if (reload) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/generador_tics.sv
// Multi-channel programmable clock divider: decodes divisor writes and fans out sync.
module generador_tics
  import divisor_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             en,
  input  logic                          sync,
  input  logic                          wr_en,
  input  logic [ch_idx_w(NUM_CH)-1:0]   wr_ch,
  input  logic [CNT_W-1:0]              wr_div,
  output logic [NUM_CH-1:0]             pend,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             clk_div
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_canal
    // Out-of-range wr_ch values never match any channel index.
    logic wr;
    assign wr = wr_en && (wr_ch == CH_W'(i));

    canal_divisor #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
    ) u_canal (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr),
      .wr_div  (wr_div),
      .pend    (pend[i]),
      .tick    (tick[i]),
      .clk_div (clk_div[i])
    );
  end

endmodule

// File: tb/tb_generador_tics.sv
// Directed bench for generador_tics with a period-length reference model checked every cycle.
module tb_generador_tics;
  localparam int NCH   = 5;
  localparam int CW    = 26;
  localparam int DINIT = 4999;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] en;
  logic           sync;
  logic           wr_en;
  logic [2:0]     wr_ch;
  logic [CW-1:0]  wr_div;
  logic [NCH-1:0] pend, tick, clk_div;

  generador_tics #(.NUM_CH(NCH), .CNT_W(CW), .DIV_INIT(DINIT)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .pend(pend), .tick(tick), .clk_div(clk_div)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act_v, input int exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Model: each channel tracks elapsed enabled cycles and a period length (divisor+1).
  int unsigned    m_pos [NCH];
  int unsigned    m_len [NCH];
  int unsigned    m_next[NCH];
  bit             m_pending[NCH];
  bit             m_tick[NCH];
  bit             m_clk[NCH];
  bit             model_ok = 0;

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        m_pos[c] = 0; m_len[c] = DINIT + 1; m_next[c] = DINIT + 1;
        m_pending[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
      end else begin
        bit wrote, at_end, swap;
        wrote  = wr_en && (int'(wr_ch) == c);
        at_end = (m_pos[c] + 1 == m_len[c]);
        swap   = m_pending[c] && (sync || !en[c] || at_end);
        m_tick[c] = 0;
        if (sync) begin
          m_pos[c] = 0; m_clk[c] = 0;
        end else if (en[c]) begin
          if (at_end) begin
            m_pos[c] = 0; m_tick[c] = 1; m_clk[c] = !m_clk[c];
          end else begin
            m_pos[c]++;
          end
        end else if (m_pending[c]) begin
          m_pos[c] = 0;
        end
        if (swap) m_len[c] = m_next[c];
        if (wrote) begin
          m_next[c] = int'(wr_div) + 1; m_pending[c] = 1;
        end else if (swap) begin
          m_pending[c] = 0;
        end
      end
    end
    model_ok = 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic [NCH-1:0] e_tick, e_clk, e_pend;
      for (int c = 0; c < NCH; c++) begin
        e_tick[c] = m_tick[c]; e_clk[c] = m_clk[c]; e_pend[c] = m_pending[c];
      end
      check("model_tick", int'(tick), int'(e_tick));
      check("model_clk_div", int'(clk_div), int'(e_clk));
      check("model_pend", int'(pend), int'(e_pend));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < limit);
  endtask

  task automatic write(input int ch, input int d);
    wr_en = 1'b1; wr_ch = 3'(ch); wr_div = CW'(d);
    step();
    wr_en = 1'b0;
  endtask

  int n;
  logic prev;

  initial begin
    reset = 1'b1; en = '1; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    repeat (3) step();
    check("reset_tick", int'(tick), 0);
    check("reset_clk_div", int'(clk_div), 0);
    check("reset_pend", int'(pend), 0);
    reset = 1'b0;

    // Default divisor: first tick 5000 cycles after release, then every 5000.
    wait_tick(0, 6000, n);
    check("ch0_first_tick", n, 5000);
    check("ch0_clk_high", int'(clk_div[0]), 1);
    wait_tick(0, 6000, n);
    check("ch0_second_tick", n, 5000);
    check("ch0_clk_low", int'(clk_div[0]), 0);

    // ch1: load D=9 while idle, then reprogram D=2 mid-period.
    en[1] = 1'b0;
    write(1, 9);
    step();
    check("ch1_idle_reload_pend", int'(pend[1]), 0);
    en[1] = 1'b1;
    repeat (4) step();
    write(1, 2);
    check("ch1_pend_after_write", int'(pend[1]), 1);
    wait_tick(1, 20, n);
    check("ch1_old_period_end", n, 5);
    check("ch1_pend_cleared", int'(pend[1]), 0);
    wait_tick(1, 20, n);
    check("ch1_new_period_a", n, 3);
    wait_tick(1, 20, n);
    check("ch1_new_period_b", n, 3);

    // ch2: D=0 ticks every cycle, then freezes while disabled.
    en[2] = 1'b0;
    write(2, 0);
    step();
    en[2] = 1'b1;
    prev = clk_div[2];
    for (int k = 0; k < 6; k++) begin
      step();
      check("ch2_d0_tick", int'(tick[2]), 1);
      check("ch2_d0_toggle", int'(clk_div[2]), int'(!prev));
      prev = clk_div[2];
    end
    en[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("ch2_idle_tick", int'(tick[2]), 0);
      check("ch2_idle_hold", int'(clk_div[2]), int'(prev));
    end
    en[2] = 1'b1;
    step();
    check("ch2_resume_tick", int'(tick[2]), 1);

    // Out-of-range channel writes are ignored.
    for (int c = NCH; c < 8; c++) begin
      write(c, 1);
      check("bad_ch_no_pend", int'(pend), 0);
    end

    // ch3 D=7, ch4 D=3, run out of phase, then realign with sync.
    en[3] = 1'b0; en[4] = 1'b0;
    write(3, 7);
    write(4, 3);
    step();
    en[3] = 1'b1;
    repeat (2) step();
    en[4] = 1'b1;
    repeat (5) step();
    sync = 1'b1;
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = CW'(20);
    step();
    sync = 1'b0; wr_en = 1'b0;
    check("sync_tick_clear", int'(tick), 0);
    check("sync_clk_clear", int'(clk_div), 0);
    check("sync_write_pending", int'(pend), 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("sync_ch4_tick", int'(tick[4]), int'(k == 4 || k == 8));
      check("sync_ch3_tick", int'(tick[3]), int'(k == 8));
    end

    // Reset mid-period with ch0 pending: pending D=20 must be discarded.
    reset = 1'b1;
    step();
    check("midreset_pend", int'(pend), 0);
    check("midreset_tick", int'(tick), 0);
    check("midreset_clk_div", int'(clk_div), 0);
    reset = 1'b0;
    wait_tick(0, 6000, n);
    check("midreset_div_init", n, 5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
